alu_op_issuer: RTL and testbench

Request-side initiator for the ALU input protocol. It accepts one operation per handshake from a local requester and drives the ALU's ce/opa/opb/mode/cmd/cin/inp_valid pins, splitting operand delivery into separate beats with a programmable gap of up to 16 cycles. It then waits the command-dependent latency, captures res, and returns it on a response handshake. It sits between a command source (sequencer or CPU-side bridge) and the ALU core, and produces only traffic the ALU input-timing rules accept.

---
 rtl/alu_op_issuer.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Request-side initiator for the ALU input protocol. It takes one operation per
// req_valid/req_ready handshake, drives the ALU pins (ce, mode, cmd, cin, opa,
// opb, inp_valid) and delivers the operands in one or two beats. Two beats are
// separated by a programmable gap. It then waits for the command-dependent
// result latency, captures res, and returns it on a rsp_valid/rsp_ready
// handshake. Only one operation is outstanding at a time.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   pause                    stall: drops ce and freezes the sequencing
//   req_valid / req_ready    request handshake (ready only in IDLE, unpaused)
//   req_mode, req_cmd,
//   req_cin                  operation fields
//   req_opa, req_opb         operands
//   req_gap                  cycles from first to second beat (clamped to MAX_GAP)
//   req_bfirst               0: A beat first, 1: B beat first
//   ce, mode, cmd, cin,
//   opa, opb                 ALU pins, held from accept until leaving RESP
//   inp_valid                bit0 = opa valid, bit1 = opb valid
//   res                      ALU result
//   rsp_valid / rsp_ready    response handshake
//   rsp_res                  captured result, held until the next capture
// -----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int DWIDTH  = 8,
    parameter int CWIDTH  = 4,
    parameter int MAX_GAP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [CWIDTH-1:0] req_cmd,
    input  logic              req_cin,
    input  logic [DWIDTH-1:0] req_opa,
    input  logic [DWIDTH-1:0] req_opb,
    input  logic [4:0]        req_gap,
    input  logic              req_bfirst,
    output logic              ce,
    output logic              mode,
    output logic [CWIDTH-1:0] cmd,
    output logic              cin,
    output logic [DWIDTH-1:0] opa,
    output logic [DWIDTH-1:0] opb,
    output logic [1:0]        inp_valid,
    input  logic [DWIDTH:0]   res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH:0]   rsp_res
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT1 = 3'd1,
        S_GAP   = 3'd2,
        S_BEAT2 = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [1:0] CLS_TWO = 2'd0;
    localparam logic [1:0] CLS_A   = 2'd1;
    localparam logic [1:0] CLS_B   = 2'd2;

    // Which operands an operation consumes; unlisted commands are two-operand.
    function automatic logic [1:0] op_class(input logic m, input logic [CWIDTH-1:0] c);
        logic [1:0] cls;
        cls = CLS_TWO;
        if (m) begin
            if (c == CWIDTH'(4) || c == CWIDTH'(5))
                cls = CLS_A;
            else if (c == CWIDTH'(6) || c == CWIDTH'(7))
                cls = CLS_B;
        end else begin
            if (c == CWIDTH'(6) || c == CWIDTH'(8) || c == CWIDTH'(9))
                cls = CLS_A;
            else if (c == CWIDTH'(7) || c == CWIDTH'(10) || c == CWIDTH'(11))
                cls = CLS_B;
        end
        return cls;
    endfunction

    function automatic logic is_mult(input logic m, input logic [CWIDTH-1:0] c);
        return m && (c == CWIDTH'(9) || c == CWIDTH'(10));
    endfunction

    state_t            state_reg, state_next;
    logic [4:0]        cnt_reg, cnt_next;

    logic              mode_reg;
    logic [CWIDTH-1:0] cmd_reg;
    logic              cin_reg;
    logic [DWIDTH-1:0] opa_reg;
    logic [DWIDTH-1:0] opb_reg;
    logic [4:0]        gap_reg;
    logic              bfirst_reg;
    logic [DWIDTH:0]   rsp_res_reg;

    logic [4:0]        req_gap_clamped;
    logic              req_single;
    logic              accept;
    logic              capture;
    logic [1:0]        lat_class;

    assign req_gap_clamped = (req_gap > 5'(MAX_GAP)) ? 5'(MAX_GAP) : req_gap;
    assign req_single      = (op_class(req_mode, req_cmd) != CLS_TWO);
    assign lat_class       = op_class(mode_reg, cmd_reg);

    assign accept  = (state_reg == S_IDLE) && req_valid && !pause;
    // Result is sampled at the edge that ends the last latency cycle.
    assign capture = (state_reg == S_WAIT) && !pause && (cnt_reg == 5'd1);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 5'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------- next-state logic ----------------
    // pause holds everything except the response handshake, so a result that
    // is already being presented can still drain.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (req_single || req_gap_clamped == 5'd0)
                        state_next = S_BEAT2;
                    else
                        state_next = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (!pause) begin
                    if (gap_reg == 5'd1) begin
                        state_next = S_BEAT2;
                    end else begin
                        state_next = S_GAP;
                        cnt_next   = gap_reg - 5'd1;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (cnt_reg == 5'd1)
                        state_next = S_BEAT2;
                    else
                        cnt_next = cnt_reg - 5'd1;
                end
            end
            S_BEAT2: begin
                if (!pause) begin
                    state_next = S_WAIT;
                    cnt_next   = is_mult(mode_reg, cmd_reg) ? 5'd3 : 5'd1;
                end
            end
            S_WAIT: begin
                if (!pause) begin
                    if (cnt_reg == 5'd1)
                        state_next = S_RESP;
                    else
                        cnt_next = cnt_reg - 5'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // ce and req_ready are qualified by rst so the ALU and the requester see
    // them low for as long as reset is held, not just after the next edge.
    always_comb begin
        ce        = rst && !pause;
        req_ready = rst && !pause && (state_reg == S_IDLE);
        rsp_valid = (state_reg == S_RESP);
        inp_valid = 2'b00;
        case (state_reg)
            S_BEAT1: inp_valid = bfirst_reg ? 2'b10 : 2'b01;
            S_BEAT2: begin
                if (lat_class == CLS_A)
                    inp_valid = 2'b01;
                else if (lat_class == CLS_B)
                    inp_valid = 2'b10;
                else if (gap_reg == 5'd0)
                    inp_valid = 2'b11;
                else
                    // complete with whichever operand BEAT1 did not carry
                    inp_valid = bfirst_reg ? 2'b01 : 2'b10;
            end
            default: inp_valid = 2'b00;
        endcase
    end

    // ---------------- operation and result registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg    <= 1'b0;
            cmd_reg     <= '0;
            cin_reg     <= 1'b0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            gap_reg     <= 5'd0;
            bfirst_reg  <= 1'b0;
            rsp_res_reg <= '0;
        end else begin
            if (accept) begin
                mode_reg   <= req_mode;
                cmd_reg    <= req_cmd;
                cin_reg    <= req_cin;
                opa_reg    <= req_opa;
                opb_reg    <= req_opb;
                gap_reg    <= req_gap_clamped;
                bfirst_reg <= req_bfirst;
            end
            if (capture)
                rsp_res_reg <= res;
        end
    end

    assign mode    = mode_reg;
    assign cmd     = cmd_reg;
    assign cin     = cin_reg;
    assign opa     = opa_reg;
    assign opb     = opb_reg;
    assign rsp_res = rsp_res_reg;

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
//
// Directed bench for alu_op_issuer. The bench plays the ALU: it drives res with
// a junk value except in the one cycle whose closing edge must capture the
// result, so a wrong latency shows up as a wrong rsp_res. Inputs are driven
// 1 time unit after the rising edge and outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;

    localparam logic [8:0] JUNK = 9'h1A5;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       req_valid;
    logic       req_ready;
    logic       req_mode;
    logic [3:0] req_cmd;
    logic       req_cin;
    logic [7:0] req_opa;
    logic [7:0] req_opb;
    logic [4:0] req_gap;
    logic       req_bfirst;
    logic       ce;
    logic       mode;
    logic [3:0] cmd;
    logic       cin;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [1:0] inp_valid;
    logic [8:0] res;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [8:0] rsp_res;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_issuer #(
        .DWIDTH (8),
        .CWIDTH (4),
        .MAX_GAP(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_cmd   (req_cmd),
        .req_cin   (req_cin),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .req_gap   (req_gap),
        .req_bfirst(req_bfirst),
        .ce        (ce),
        .mode      (mode),
        .cmd       (cmd),
        .cin       (cin),
        .opa       (opa),
        .opb       (opb),
        .inp_valid (inp_valid),
        .res       (res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":ce"},        ce,        0);
        check({tag, ":mode"},      mode,      0);
        check({tag, ":cmd"},       cmd,       0);
        check({tag, ":cin"},       cin,       0);
        check({tag, ":opa"},       opa,       0);
        check({tag, ":opb"},       opb,       0);
        check({tag, ":inp_valid"}, inp_valid, 0);
        check({tag, ":req_ready"}, req_ready, 0);
        check({tag, ":rsp_valid"}, rsp_valid, 0);
        check({tag, ":rsp_res"},   rsp_res,   0);
    endtask

    // One full transaction. g = expected clamped gap (0 for a single/combined
    // beat), l = expected latency, iv1/iv2 = expected first/completing beat,
    // r = hand-computed ALU result presented in the capture cycle.
    task automatic run_op(input string tag, input logic md, input logic [3:0] cm,
                          input logic ci, input logic [7:0] a, input logic [7:0] b,
                          input logic [4:0] gap, input logic bf,
                          input int g, input int l,
                          input logic [1:0] iv1, input logic [1:0] iv2,
                          input logic [8:0] r);
        int c;
        logic [1:0] exp_iv;
        c = 1 + g;
        step();
        req_mode   = md;
        req_cmd    = cm;
        req_cin    = ci;
        req_opa    = a;
        req_opb    = b;
        req_gap    = gap;
        req_bfirst = bf;
        req_valid  = 1'b1;
        res        = JUNK;
        #1;
        check({tag, ":req_ready"}, req_ready, 1);
        for (int k = 1; k <= c + l; k++) begin
            step();
            req_valid = 1'b0;
            req_opa   = ~a;
            req_cmd   = ~cm;
            res       = (k == c + l) ? r : JUNK;
            #1;
            if (k == c)      exp_iv = iv2;
            else if (k == 1) exp_iv = iv1;
            else             exp_iv = 2'b00;
            check($sformatf("%s:iv@%0d", tag, k), inp_valid, exp_iv);
            check($sformatf("%s:rsp_valid@%0d", tag, k), rsp_valid, 0);
            if (k == c) begin
                check({tag, ":ce"},   ce,   1);
                check({tag, ":mode"}, mode, md);
                check({tag, ":cmd"},  cmd,  cm);
                check({tag, ":cin"},  cin,  ci);
                check({tag, ":opa"},  opa,  a);
                check({tag, ":opb"},  opb,  b);
            end
        end
        step();
        res       = JUNK;
        rsp_ready = 1'b1;
        #1;
        check({tag, ":rsp_valid"}, rsp_valid, 1);
        check({tag, ":rsp_res"},   rsp_res,   r);
        check({tag, ":busy_ready"}, req_ready, 0);
        step();
        rsp_ready = 1'b0;
        #1;
        check({tag, ":rsp_done"},  rsp_valid, 0);
        check({tag, ":idle_ready"}, req_ready, 1);
        $display("op %s: gap %0d latency %0d rsp_res 0x%03h", tag, g, l, rsp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_iv;
        logic       p;

        rst        = 1'b0;
        pause      = 1'b0;
        req_valid  = 1'b0;
        req_mode   = 1'b0;
        req_cmd    = 4'd0;
        req_cin    = 1'b0;
        req_opa    = 8'd0;
        req_opb    = 8'd0;
        req_gap    = 5'd0;
        req_bfirst = 1'b0;
        rsp_ready  = 1'b0;
        res        = JUNK;

        // ---------------- reset state ----------------
        #3;
        check_all_zero("reset");
        step();
        step();
        rst = 1'b1;
        #1;
        check("post_reset:req_ready", req_ready, 1);
        check("post_reset:ce",        ce,        1);
        check("post_reset:inp_valid", inp_valid, 0);
        check("post_reset:rsp_valid", rsp_valid, 0);
        $display("reset released");

        // ---------------- directed operations ----------------
        //      tag              md cmd cin opa    opb    gap    bf  g   l  iv1    iv2    res
        run_op("add_gap0",      1, 0,  0, 8'h0F, 8'h01, 5'd0,  0,  0,  1, 2'b00, 2'b11, 9'h010);
        run_op("and_gap5_bf",   0, 0,  0, 8'hF0, 8'h3C, 5'd5,  1,  5,  1, 2'b10, 2'b01, 9'h030);
        run_op("shmul_gap20",   1, 10, 0, 8'h03, 8'h04, 5'd20, 0,  16, 3, 2'b01, 2'b10, 9'h018);
        run_op("incb_gap9",     1, 6,  1, 8'h11, 8'h22, 5'd9,  0,  0,  1, 2'b00, 2'b10, 9'h023);
        run_op("nota_gap3",     0, 6,  0, 8'h55, 8'h00, 5'd3,  1,  0,  1, 2'b00, 2'b01, 9'h0AA);
        run_op("incmul_gap1",   1, 9,  1, 8'h03, 8'h04, 5'd1,  1,  1,  3, 2'b10, 2'b01, 9'h014);
        run_op("add_gap16",     1, 0,  1, 8'h80, 8'h80, 5'd16, 1,  16, 1, 2'b10, 2'b01, 9'h100);

        // ---------------- pause for 4 cycles in the gap ----------------
        // NAND, gap 4: unpaused the second beat would be at E+5; 4 paused
        // cycles move it to E+9, capture at the end of E+10, RESP at E+11.
        step();
        req_mode   = 1'b0;
        req_cmd    = 4'd1;
        req_cin    = 1'b0;
        req_opa    = 8'hF0;
        req_opb    = 8'hCC;
        req_gap    = 5'd4;
        req_bfirst = 1'b0;
        req_valid  = 1'b1;
        #1;
        check("pause:req_ready", req_ready, 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            req_valid = 1'b0;
            p         = (k >= 3 && k <= 6);
            pause     = p;
            res       = (k == 10) ? 9'h03F : JUNK;
            #1;
            if (k == 1)      exp_iv = 2'b01;
            else if (k == 9) exp_iv = 2'b10;
            else             exp_iv = 2'b00;
            check($sformatf("pause:iv@%0d", k), inp_valid, exp_iv);
            check($sformatf("pause:ce@%0d", k), ce, !p);
            check($sformatf("pause:rsp_valid@%0d", k), rsp_valid, 0);
            if (p) begin
                check($sformatf("pause:cmd@%0d", k), cmd, 1);
                check($sformatf("pause:req_ready@%0d", k), req_ready, 0);
            end
        end
        // Response drains even while paused.
        step();
        pause     = 1'b1;
        rsp_ready = 1'b1;
        res       = JUNK;
        #1;
        check("pause:rsp_valid", rsp_valid, 1);
        check("pause:rsp_res",   rsp_res,   9'h03F);
        check("pause:resp_ce",   ce,        0);
        step();
        rsp_ready = 1'b0;
        #1;
        check("pause:rsp_drained",    rsp_valid, 0);
        check("pause:idle_req_ready", req_ready, 0);
        step();
        pause = 1'b0;
        #1;
        check("pause:resume_ready", req_ready, 1);
        $display("op pause_nand: rsp_res 0x%03h", rsp_res);

        // ---------------- reset during WAIT ----------------
        step();
        req_mode   = 1'b1;
        req_cmd    = 4'd9;
        req_cin    = 1'b1;
        req_opa    = 8'h03;
        req_opb    = 8'h04;
        req_gap    = 5'd0;
        req_bfirst = 1'b0;
        req_valid  = 1'b1;
        step();                 // E+1: combined beat
        req_valid = 1'b0;
        #1;
        check("rst_op:iv", inp_valid, 2'b11);
        step();                 // E+2: WAIT
        step();                 // E+3: WAIT
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_wait");
        step();
        #1;
        check("rst_hold:rsp_valid", rsp_valid, 0);
        step();
        rst = 1'b1;
        #1;
        check("rst_rel:req_ready", req_ready, 1);
        check("rst_rel:ce",        ce,        1);
        check("rst_rel:inp_valid", inp_valid, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            res = 9'h014;
            #1;
            check($sformatf("rst_drop:rsp_valid@%0d", k), rsp_valid, 0);
        end
        $display("op reset_in_wait: dropped, rsp_res 0x%03h", rsp_res);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
